seqmul_param: RTL and testbench

- Parametrised, handshaked successor to the 4-bit shift-add sequential multiplier.
- Multiplies two N-bit operands over N iteration cycles, one iteration per cycle.
- Runtime mode select: unsigned shift-add, or signed two's-complement radix-2 Booth.
- Used as a shared multi-cycle multiplier behind a start/done handshake in datapaths where a combinational array multiplier is too large.

---
 rtl/seqmul_param.sv | 106 ++++++++++
 tb/tb_seqmul_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seqmul_param.sv
// Sequential N-bit multiplier: unsigned shift-add or signed radix-2 Booth,
// one iteration per clock behind a start/ready/done handshake.
module seqmul_param #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   Min,
  input  logic [N-1:0]   Qin,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N:0]    a;
  logic [N-1:0]  q;
  logic [N-1:0]  m;
  logic          q_1;
  logic          mode;
  logic [CW-1:0] count;

  logic [N:0]    a_sum;
  logic [N:0]    a_next;
  logic [N-1:0]  q_next;
  logic          q_1_next;

  // One iteration: conditional add/subtract into the accumulator, then a
  // right shift of {A,Q,Q_1}. In unsigned mode the guard bit acts as the carry.
  always_comb begin
    a_sum    = a;
    a_next   = a;
    q_next   = q;
    q_1_next = q[0];
    if (mode) begin
      case ({q[0], q_1})
        2'b01:   a_sum = a + {m[N-1], m};
        2'b10:   a_sum = a - {m[N-1], m};
        default: a_sum = a;
      endcase
      a_next = {a_sum[N], a_sum[N:1]};
    end else begin
      if (q[0])
        a_sum = {1'b0, a[N-1:0]} + {1'b0, m};
      else
        a_sum = {1'b0, a[N-1:0]};
      a_next = {1'b0, a_sum[N:1]};
    end
    q_next = {a_sum[0], q[N-1:1]};
  end

  // Control and datapath registers; product only moves on entering DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      q_1     <= 1'b0;
      mode    <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m     <= Min;
            q     <= Qin;
            a     <= '0;
            q_1   <= 1'b0;
            mode  <= signed_mode;
            count <= CW'(N);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a     <= a_next;
          q     <= q_next;
          q_1   <= q_1_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state   <= DONE;
            product <= {a_next[N-1:0], q_next};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_seqmul_param.sv
// Self-checking bench for seqmul_param: directed cases at N=4 and N=8 plus
// randomized operations compared against an arithmetic reference product.
module tb_seqmul_param;

  logic clk;
  logic reset;

  logic        start4, sm4;
  logic [3:0]  m4, q4;
  logic        ready4, busy4, done4;
  logic [7:0]  prod4;

  logic        start8, sm8;
  logic [7:0]  m8, q8;
  logic        ready8, busy8, done8;
  logic [15:0] prod8;

  int total = 0;
  int bad   = 0;
  logic [7:0] lastExp4 = '0;

  seqmul_param #(.N(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
    .Min(m4), .Qin(q4), .ready(ready4), .busy(busy4), .done(done4),
    .product(prod4)
  );

  seqmul_param #(.N(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .Min(m8), .Qin(q8), .ready(ready8), .busy(busy8), .done(done8),
    .product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands per mode, multiply as integers, keep 2N bits
  function automatic logic [15:0] refProd(input int n, input bit sm,
                                          input logic [7:0] a, input logic [7:0] b);
    longint x, y, p;
    longint mask;
    mask = (64'sd1 <<< n) - 1;
    x = longint'(a) & mask;
    y = longint'(b) & mask;
    if (sm) begin
      if (x >= (64'sd1 <<< (n - 1))) x = x - (64'sd1 <<< n);
      if (y >= (64'sd1 <<< (n - 1))) y = y - (64'sd1 <<< n);
    end
    p = x * y;
    return 16'(p & ((64'sd1 <<< (2 * n)) - 1));
  endfunction

  task automatic setIn(input bit wide, input logic st, input bit sm,
                       input logic [7:0] ma, input logic [7:0] qa);
    if (wide) begin
      start8 = st; sm8 = sm; m8 = ma; q8 = qa;
    end else begin
      start4 = st; sm4 = sm; m4 = ma[3:0]; q4 = qa[3:0];
    end
  endtask

  // Full operation: checks latency, busy length and product; operands are
  // scrambled and start re-pulsed while busy, which must have no effect.
  task automatic applyStimulus(input bit wide, input bit sm, input logic [7:0] ma,
                               input logic [7:0] qa, input string tag);
    int n;
    int cyc;
    int busyCyc;
    bit seen;
    logic [15:0] exp;
    n = wide ? 8 : 4;
    cyc = 0;
    busyCyc = 0;
    seen = 0;
    exp = refProd(n, sm, ma, qa);
    setIn(wide, 1'b1, sm, ma, qa);
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) setIn(wide, 1'b0, ~sm, 8'($urandom), 8'($urandom));
      if (cyc == 2) setIn(wide, 1'($urandom), ~sm, 8'($urandom), 8'($urandom));
      if (cyc == 3) setIn(wide, 1'b0, sm, 8'($urandom), 8'($urandom));
      if (wide ? busy8 : busy4) busyCyc++;
      if (wide ? done8 : done4) seen = 1;
    end
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(n + 1));
    checkOutput({tag, "_busy"}, 64'(busyCyc), 64'(n));
    checkOutput({tag, "_prod"}, wide ? 64'(prod8) : 64'(prod4), 64'(exp));
    if (!wide) lastExp4 = exp[7:0];
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] bm [4];
    logic [3:0] bq [4];
    bit         bs [4];
    logic [7:0] bexp [4];
    int gap, k, nxt, unstable, cyc;
    bit sawDone;

    reset = 1'b0;
    setIn(1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
    setIn(1'b1, 1'b0, 1'b0, 8'h0, 8'h0);
    #1;
    checkOutput("rst_ready", 64'(ready4), 64'(1));
    checkOutput("rst_busy", 64'(busy4), 64'(0));
    checkOutput("rst_done", 64'(done4), 64'(0));
    checkOutput("rst_prod", 64'(prod4), 64'(0));
    checkOutput("rst_prod8", 64'(prod8), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    applyStimulus(1'b0, 1'b0, 8'hD, 8'hB, "u13x11");
    checkOutput("u13x11_abs", 64'(prod4), 64'(143));
    applyStimulus(1'b0, 1'b1, 8'hD, 8'hB, "sm3xm5");
    checkOutput("sm3xm5_abs", 64'(prod4), 64'h0F);
    applyStimulus(1'b0, 1'b1, 8'h8, 8'h7, "sm8x7");
    checkOutput("sm8x7_abs", 64'(prod4), 64'hC8);
    applyStimulus(1'b0, 1'b0, 8'hF, 8'hF, "u15x15");
    checkOutput("u15x15_abs", 64'(prod4), 64'hE1);
    applyStimulus(1'b0, 1'b1, 8'hF, 8'hF, "sm1xm1");
    checkOutput("sm1xm1_abs", 64'(prod4), 64'h01);
    applyStimulus(1'b0, 1'b0, 8'h0, 8'h9, "u0x9");
    applyStimulus(1'b0, 1'b1, 8'h9, 8'h0, "s9x0");
    applyStimulus(1'b0, 1'b1, 8'h8, 8'h8, "sm8xm8");
    checkOutput("sm8xm8_abs", 64'(prod4), 64'h40);
    applyStimulus(1'b1, 1'b1, 8'h80, 8'h80, "s80x80");
    checkOutput("s80x80_abs", 64'(prod8), 64'h4000);
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'hFF, "uFFxFF");
    checkOutput("uFFxFF_abs", 64'(prod8), 64'hFE01);

    // Start re-pulsed in RUN cycle 2 is ignored; no follow-on operation
    setIn(1'b0, 1'b1, 1'b0, 8'hD, 8'hB);
    cyc = 0;
    sawDone = 0;
    while (!sawDone && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) setIn(1'b0, 1'b0, 1'b0, 8'hD, 8'hB);
      if (cyc == 2) setIn(1'b0, 1'b1, 1'b1, 8'h2, 8'h3);
      if (cyc == 3) setIn(1'b0, 1'b0, 1'b0, 8'h2, 8'h3);
      if (done4) sawDone = 1;
    end
    checkOutput("repulse_latency", 64'(cyc), 64'(5));
    checkOutput("repulse_prod", 64'(prod4), 64'(143));
    @(negedge clk);
    checkOutput("repulse_idle_busy", 64'(busy4), 64'(0));
    checkOutput("repulse_idle_ready", 64'(ready4), 64'(1));
    lastExp4 = 8'd143;

    // Back-to-back with start held high through each DONE cycle
    for (int i = 0; i < 4; i++) begin
      bm[i] = 4'($urandom);
      bq[i] = 4'($urandom);
      bs[i] = 1'($urandom);
      bexp[i] = refProd(4, bs[i], 8'(bm[i]), 8'(bq[i]));
    end
    setIn(1'b0, 1'b1, bs[0], 8'(bm[0]), 8'(bq[0]));
    gap = 0; k = 0; nxt = 1; unstable = 0; cyc = 0;
    while (k < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      gap++;
      if (gap == 1) begin
        if (nxt < 4) begin
          setIn(1'b0, 1'b1, bs[nxt], 8'(bm[nxt]), 8'(bq[nxt]));
          nxt++;
        end else begin
          start4 = 1'b0;
        end
      end
      if (done4) begin
        checkOutput($sformatf("b2b%0d_gap", k), 64'(gap), 64'(5));
        checkOutput($sformatf("b2b%0d_prod", k), 64'(prod4), 64'(bexp[k]));
        lastExp4 = bexp[k];
        k++;
        gap = 0;
      end else if (prod4 !== lastExp4) begin
        unstable++;
      end
    end
    checkOutput("b2b_count", 64'(k), 64'(4));
    checkOutput("b2b_prod_stable", 64'(unstable), 64'(0));
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Asynchronous reset in RUN cycle 2 aborts the operation
    setIn(1'b0, 1'b1, 1'b0, 8'hD, 8'hB);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_busy", 64'(busy4), 64'(0));
    checkOutput("arst_ready", 64'(ready4), 64'(1));
    checkOutput("arst_prod", 64'(prod4), 64'(0));
    checkOutput("arst_done", 64'(done4), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    sawDone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4 || busy4) sawDone = 1;
    end
    checkOutput("arst_no_done", 64'(sawDone), 64'(0));
    applyStimulus(1'b0, 1'b0, 8'h6, 8'h7, "u6x7");
    checkOutput("u6x7_abs", 64'(prod4), 64'(42));

    // Randomized operations on both widths and modes
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), $sformatf("rnd4_%0d", i));
      applyStimulus(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), $sformatf("rnd8_%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
